// File: rtl/universal_shift_register_param.sv
// Parametrised multi-mode shift register with a start/busy/done sequencer that
// applies one single-bit shift, rotate or serial step per clock cycle.
module universal_shift_register_param #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amount,
  input  logic             serial_in_l,
  input  logic             serial_in_r,
  output logic [WIDTH-1:0] parallel_out,
  output logic             serial_out_l,
  output logic             serial_out_r,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] data_reg, data_next;
  logic [AMT_W-1:0] count_reg, count_next;
  logic [2:0]       mode_reg, mode_next;
  logic [WIDTH-1:0] step_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      data_reg  <= '0;
      count_reg <= '0;
      mode_reg  <= '0;
    end else begin
      state_reg <= state_next;
      data_reg  <= data_next;
      count_reg <= count_next;
      mode_reg  <= mode_next;
    end
  end

  // One single-bit step of the latched mode; mode 7 holds the register.
  always_comb begin
    step_value = data_reg;
    case (mode_reg)
      3'd0: step_value = {data_reg[WIDTH-2:0], 1'b0};
      3'd1: step_value = {1'b0, data_reg[WIDTH-1:1]};
      3'd2: step_value = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
      3'd3: step_value = {data_reg[0], data_reg[WIDTH-1:1]};
      3'd4: step_value = {data_reg[WIDTH-1], data_reg[WIDTH-1:1]};
      3'd5: step_value = {data_reg[WIDTH-2:0], serial_in_r};
      3'd6: step_value = {serial_in_l, data_reg[WIDTH-1:1]};
      default: step_value = data_reg;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
    case (state_reg)
      IDLE: begin
        if (load) begin
          data_next = parallel_in;
        end else if (start) begin
          mode_next  = mode;
          count_next = amount;
          state_next = (amount == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_next  = step_value;
        count_next = count_reg - AMT_W'(1);
        if (count_reg == AMT_W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign parallel_out = data_reg;
  assign serial_out_l = data_reg[WIDTH-1];
  assign serial_out_r = data_reg[0];
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);

endmodule

// File: tb/tb_universal_shift_register_param.sv
// Randomised and directed bench for universal_shift_register_param, checked
// against an arithmetic model of the N-step shift result.
module tb_universal_shift_register_param;
  localparam int W = 8;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] parallel_in = '0;
  logic         start = 1'b0;
  logic [2:0]   mode = '0;
  logic [A-1:0] amount = '0;
  logic         serial_in_l = 1'b0;
  logic         serial_in_r = 1'b0;
  logic [W-1:0] parallel_out;
  logic         serial_out_l, serial_out_r, busy, done;

  int checks = 0;
  int errors = 0;

  universal_shift_register_param #(.WIDTH(W), .AMT_W(A)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .parallel_in(parallel_in),
    .start(start), .mode(mode), .amount(amount),
    .serial_in_l(serial_in_l), .serial_in_r(serial_in_r),
    .parallel_out(parallel_out), .serial_out_l(serial_out_l),
    .serial_out_r(serial_out_r), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Result of n steps of mode m, computed as whole-word arithmetic.
  function automatic logic [W-1:0] model(input logic [W-1:0] v, input int m, input int n,
                                         input logic [15:0] bl, input logic [15:0] br);
    logic [W-1:0] r;
    int s;
    r = v;
    s = n % W;
    case (m)
      0: r = (n >= W) ? '0 : W'(v << n);
      1: r = (n >= W) ? '0 : W'(v >> n);
      2: r = (s == 0) ? v : W'((v << s) | (v >> (W - s)));
      3: r = (s == 0) ? v : W'((v >> s) | (v << (W - s)));
      4: r = (n >= W) ? {W{v[W-1]}} : W'($signed(v) >>> n);
      5: for (int k = 0; k < n; k++) r = W'((r << 1) | W'(br[k]));
      6: for (int k = 0; k < n; k++) r = W'((r >> 1) | (W'(bl[k]) << (W - 1)));
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    parallel_in = v;
    @(negedge clk);
    load = 1'b0;
    parallel_in = W'($urandom);
  endtask

  // Starts a sequence at the current negedge and follows it until busy drops.
  task automatic run_seq(input int m, input int n, input logic [15:0] bl, input logic [15:0] br,
                         input bit load_mid, output logic [W-1:0] final_v,
                         output int busy_cyc, output int done_cyc, output int done_pos);
    start = 1'b1;
    mode = 3'(m);
    amount = A'(n);
    @(negedge clk);
    start = 1'b0;
    mode = 3'($urandom);
    amount = A'($urandom);
    busy_cyc = 0;
    done_cyc = 0;
    done_pos = -1;
    while (busy && busy_cyc < 64) begin
      if (done) begin
        done_cyc++;
        done_pos = busy_cyc;
      end
      serial_in_l = (busy_cyc < 16) ? bl[busy_cyc] : 1'b0;
      serial_in_r = (busy_cyc < 16) ? br[busy_cyc] : 1'b0;
      load = load_mid && (busy_cyc == 1);
      parallel_in = {W{1'b1}};
      busy_cyc++;
      @(negedge clk);
    end
    load = 1'b0;
    final_v = parallel_out;
  endtask

  task automatic check_seq(input string name, input logic [W-1:0] exp_v, input int n,
                           input logic [W-1:0] got_v, input int bc, input int dc, input int dp);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s value: got %h expected %h", name, got_v, exp_v);
    end
    checks++;
    if (bc !== n + 1) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, bc, n + 1);
    end
    checks++;
    if (dc !== 1 || dp !== n) begin
      errors++;
      $display("FAIL %s done: got count %0d at %0d expected count 1 at %0d", name, dc, dp, n);
    end
    $display("seq %s: value %h busy %0d done %0d@%0d", name, got_v, bc, dc, dp);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({parallel_out, serial_out_l, serial_out_r, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset: got out=%h sl=%b sr=%b busy=%b done=%b expected all 0",
               parallel_out, serial_out_l, serial_out_r, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_load();
    do_load(8'hA5);
    checks++;
    if (parallel_out !== 8'hA5 || busy !== 1'b0 || done !== 1'b0 ||
        serial_out_l !== 1'b1 || serial_out_r !== 1'b1) begin
      errors++;
      $display("FAIL load: got out=%h busy=%b done=%b sl=%b sr=%b expected a5 0 0 1 1",
               parallel_out, busy, done, serial_out_l, serial_out_r);
    end
    // load and start together: load wins, start is dropped
    load = 1'b1; start = 1'b1; parallel_in = 8'h3E; mode = 3'd0; amount = 4'd3;
    @(negedge clk);
    load = 1'b0; start = 1'b0;
    checks++;
    if (parallel_out !== 8'h3E || busy !== 1'b0) begin
      errors++;
      $display("FAIL load_priority: got out=%h busy=%b expected 3e 0", parallel_out, busy);
    end
    @(negedge clk);
    checks++;
    if (parallel_out !== 8'h3E || busy !== 1'b0) begin
      errors++;
      $display("FAIL hold: got out=%h busy=%b expected 3e 0", parallel_out, busy);
    end
    $display("load: out %h", parallel_out);
  endtask

  task automatic test_directed();
    logic [W-1:0] v;
    int bc, dc, dp;
    do_load(8'h81);
    run_seq(2, 3, '0, '0, 1'b0, v, bc, dc, dp);
    check_seq("rotl3", 8'h0C, 3, v, bc, dc, dp);
    do_load(8'h90);
    run_seq(4, 2, '0, '0, 1'b0, v, bc, dc, dp);
    check_seq("asr2", 8'hE4, 2, v, bc, dc, dp);
    do_load(8'hFF);
    run_seq(0, 10, '0, '0, 1'b0, v, bc, dc, dp);
    check_seq("lsl10", 8'h00, 10, v, bc, dc, dp);
  endtask

  task automatic test_zero_amount();
    logic [W-1:0] v;
    int bc, dc, dp;
    do_load(8'h3C);
    run_seq(0, 0, '0, '0, 1'b0, v, bc, dc, dp);
    check_seq("amt0", 8'h3C, 0, v, bc, dc, dp);
  endtask

  task automatic test_serial_load_ignored();
    logic [W-1:0] v;
    int bc, dc, dp;
    do_load(8'h00);
    run_seq(6, 4, 16'b1101, '0, 1'b1, v, bc, dc, dp);
    check_seq("serial_r4", 8'hD0, 4, v, bc, dc, dp);
  endtask

  task automatic test_reset_abort();
    logic [W-1:0] v;
    int bc, dc, dp;
    do_load(8'hFF);
    start = 1'b1; mode = 3'd1; amount = 4'd8;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (parallel_out !== 8'h1F || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: got out=%h busy=%b expected 1f 1", parallel_out, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({parallel_out, serial_out_l, serial_out_r, busy, done} !== '0) begin
      errors++;
      $display("FAIL abort_reset: got out=%h busy=%b done=%b expected all 0",
               parallel_out, busy, done);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL abort_no_done: got busy=%b done=%b expected 0 0", busy, done);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_load(8'h5A);
    run_seq(3, 1, '0, '0, 1'b0, v, bc, dc, dp);
    check_seq("after_abort", 8'h2D, 1, v, bc, dc, dp);
  endtask

  // Back-to-back random sequences; a reload happens only on some iterations.
  task automatic test_random();
    logic [W-1:0] v, cur, expv;
    logic [15:0] bl, br;
    int m, n, bc, dc, dp;
    cur = parallel_out;
    for (int i = 0; i < 24; i++) begin
      if (i % 3 == 0) begin
        cur = W'($urandom);
        do_load(cur);
      end
      m = int'($urandom_range(0, 7));
      n = int'($urandom_range(0, 15));
      bl = 16'($urandom);
      br = 16'($urandom);
      expv = model(cur, m, n, bl, br);
      run_seq(m, n, bl, br, 1'b0, v, bc, dc, dp);
      check_seq($sformatf("rand%0d_m%0d_n%0d", i, m, n), expv, n, v, bc, dc, dp);
      cur = expv;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_directed();
    test_zero_amount();
    test_serial_load_ignored();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
